// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 access codes, LSU state
// enum and access legality helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_e;

  function automatic logic load_f3_ok(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_H) ||
           (f3 == F3_W) || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_H) ||
           (f3 == F3_W);
  endfunction

  // Size lives in f3[1:0] for both loads and stores.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / lane-replicated
// write data, and load lane extract with sign or zero extension.
// Ports: funct3, offset (addr[1:0]), store_data, bus_rdata in;
//        be, wdata, load_data out. Purely combinational.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    sh_b   = bus_rdata >> {offset, 3'b000};
    sh_h   = bus_rdata >> {offset[1], 4'b0000};
    lane_b = sh_b[7:0];
    lane_h = sh_h[15:0];
    sext   = ~funct3[2];
    be        = 4'b1111;
    wdata     = store_data;
    load_data = bus_rdata;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sext & lane_b[7]}}, lane_b};
      end
      funct3[1:0] == 2'b01: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sext & lane_h[15]}}, lane_h};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: req/ack data bus master with byte enables,
// formatted load return, pipeline stall and error pulses.
// Ports: pipeline side (mem_valid, mem_re, memrwM, funct3M, ALUresM,
//        data_writeM, data_readM, load_valid, stall_mem, misalign,
//        illegal, bus_err); bus side (dmem_req, dmem_we, dmem_addr,
//        dmem_wdata, dmem_be, dmem_ack, dmem_rdata).
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_re,
  input  logic              memrwM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUresM,
  input  logic [31:0]       data_writeM,
  output logic [31:0]       data_readM,
  output logic              load_valid,
  output logic              stall_mem,
  output logic              misalign,
  output logic              illegal,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  lsu_state_e state, state_n;

  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          op, bad, mis, accept;
  logic          ack_ok, expire;
  logic [2:0]    f3_sel;
  logic [1:0]    off_sel;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   load_c;

  // Store formatting uses live inputs at accept;
  // load formatting uses the latched op.
  assign f3_sel  = (state == IDLE) ? funct3M : f3_q;
  assign off_sel = (state == IDLE) ? ALUresM[1:0] : off_q;

  lsu_align u_align (
    .funct3     (f3_sel),
    .offset     (off_sel),
    .store_data (data_writeM),
    .bus_rdata  (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_c)
  );

  always_comb begin
    op  = mem_valid && (mem_re || memrwM);
    bad = op && ((mem_re && memrwM) ||
          (mem_re  && !load_f3_ok(funct3M)) ||
          (memrwM && !store_f3_ok(funct3M)));
    mis = op && !bad &&
          misaligned(funct3M, ALUresM[1:0]);
    accept = (state == IDLE) && op && !bad && !mis;
    ack_ok = (state == BUSY) && dmem_ack;
    // Ack wins over an expiring counter.
    expire = (state == BUSY) && !dmem_ack &&
             (cnt == LAST);
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (ack_ok || expire) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign stall_mem = accept || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      data_readM <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
      illegal    <= (state == IDLE) && bad;
      misalign   <= (state == IDLE) && mis;
      bus_err    <= expire;
      load_valid <= ack_ok && !we_q;
      dmem_req   <= (state_n == BUSY);
      dmem_we    <= (state_n == BUSY) &&
                    (accept ? memrwM : we_q);
      if (accept) begin
        we_q       <= memrwM;
        f3_q       <= funct3M;
        off_q      <= ALUresM[1:0];
        dmem_addr  <= {ALUresM[ADDR_W-1:2], 2'b00};
        dmem_wdata <= wdata_c;
        dmem_be    <= be_c;
      end
      if (ack_ok && !we_q) data_readM <= load_c;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: scoreboard of expected bus
// transactions and load results, one task per scenario.
module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_re, memrwM;
  logic [2:0]  funct3M;
  logic [31:0] ALUresM, data_writeM, data_readM;
  logic        load_valid, stall_mem, misalign;
  logic        illegal, bus_err;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  lsu_mem_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_re      (mem_re),
    .memrwM      (memrwM),
    .funct3M     (funct3M),
    .ALUresM     (ALUresM),
    .data_writeM (data_writeM),
    .data_readM  (data_readM),
    .load_valid  (load_valid),
    .stall_mem   (stall_mem),
    .misalign    (misalign),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] load_q[$];

  int checks = 0;
  int errors = 0;

  int          n_stall, n_req;
  int          lv_cyc, berr_cyc, mis_cyc, ill_cyc;
  logic [31:0] lv_data, obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  // Drives one op in cycle 0, acks in cycle ack_at (0 = never),
  // and records what the DUT shows over ncyc cycles.
  task automatic run_op(
    input logic        re,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          ack_at,
    input int          ncyc
  );
    n_stall = 0; n_req = 0;
    lv_cyc = -1; berr_cyc = -1;
    mis_cyc = -1; ill_cyc = -1;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_re = re; memrwM = we;
    funct3M = f3; ALUresM = addr;
    data_writeM = wd; dmem_ack = 1'b0;
    dmem_rdata = rd;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_re = 1'b0;
        memrwM = 1'b0;
        dmem_ack = (c == ack_at);
      end
      @(negedge clk);
      if (stall_mem) n_stall++;
      if (dmem_req) begin
        if (n_req == 0) begin
          obs_addr = dmem_addr; obs_we = dmem_we;
          obs_be = dmem_be; obs_wdata = dmem_wdata;
        end
        n_req++;
      end
      if (load_valid) begin
        lv_cyc = c; lv_data = data_readM;
      end
      if (bus_err)  berr_cyc = c;
      if (misalign) mis_cyc = c;
      if (illegal)  ill_cyc = c;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_re = 1'b0;
    memrwM = 1'b0; funct3M = 3'b000;
    ALUresM = '0; data_writeM = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({data_readM, load_valid, stall_mem, misalign,
         illegal, bus_err, dmem_req, dmem_we,
         dmem_addr, dmem_wdata, dmem_be} !== '0) begin
      errors++;
      $display("FAIL reset: rd=%h lv=%b st=%b req=%b addr=%h be=%b, all required 0",
               data_readM, load_valid, stall_mem,
               dmem_req, dmem_addr, dmem_be);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_store_word();
    bus_exp_t x;
    bus_q.push_back('{1'b1, 32'h100, 4'b1111,
                      32'hDEADBEEF});
    run_op(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF,
           32'h0, 2, 5);
    checks++;
    if (n_stall !== 3 || n_req !== 2 || lv_cyc !== -1) begin
      errors++;
      $display("FAIL sw_timing: stall=%0d req=%0d lv=%0d required 3 2 -1",
               n_stall, n_req, lv_cyc);
    end
    x = bus_q.pop_front();
    checks++;
    if (obs_addr !== x.addr || obs_we !== x.we ||
        obs_be !== x.be || obs_wdata !== x.wdata) begin
      errors++;
      $display("FAIL sw_bus: %h %b %b %h required %h %b %b %h",
               obs_addr, obs_we, obs_be, obs_wdata,
               x.addr, x.we, x.be, x.wdata);
    end
  endtask

  task automatic test_load_byte();
    bus_exp_t x;
    logic [2:0] f3s [2];
    logic [31:0] want;
    f3s[0] = F3_B; f3s[1] = F3_BU;
    for (int i = 0; i < 2; i++) begin
      bus_q.push_back('{1'b0, 32'h200, 4'b0, 32'h0});
      load_q.push_back(i == 0 ? 32'hFFFFFF80 : 32'h00000080);
      run_op(1'b1, 1'b0, f3s[i], 32'h203, 32'h0,
             32'h80FF7F01, 1, 4);
      checks++;
      if (n_stall !== 2 || n_req !== 1 || lv_cyc !== 2) begin
        errors++;
        $display("FAIL lb_timing[%0d]: stall=%0d req=%0d lv=%0d required 2 1 2",
                 i, n_stall, n_req, lv_cyc);
      end
      x = bus_q.pop_front();
      checks++;
      if (obs_addr !== x.addr || obs_we !== x.we) begin
        errors++;
        $display("FAIL lb_bus[%0d]: addr=%h we=%b required %h %b",
                 i, obs_addr, obs_we, x.addr, x.we);
      end
      want = load_q.pop_front();
      checks++;
      if (lv_data !== want) begin
        errors++;
        $display("FAIL lb_data[%0d]: got %h required %h",
                 i, lv_data, want);
      end
    end
  endtask

  task automatic test_store_half();
    bus_exp_t x;
    bus_q.push_back('{1'b1, 32'h10, 4'b1100,
                      32'hA5C3A5C3});
    run_op(1'b0, 1'b1, F3_H, 32'h12, 32'h0000A5C3,
           32'h0, 1, 4);
    x = bus_q.pop_front();
    checks++;
    if (n_req !== 1 || obs_addr !== x.addr ||
        obs_we !== x.we || obs_be !== x.be ||
        obs_wdata !== x.wdata) begin
      errors++;
      $display("FAIL sh_bus: n=%0d %h %b %b %h required 1 %h %b %b %h",
               n_req, obs_addr, obs_we, obs_be, obs_wdata,
               x.addr, x.we, x.be, x.wdata);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b1, 1'b0, F3_H, 32'h11, 32'h0,
           32'h0, 0, 4);
    checks++;
    if (mis_cyc !== 1 || n_req !== 0 || n_stall !== 0 ||
        ill_cyc !== -1) begin
      errors++;
      $display("FAIL misalign: mis=%0d req=%0d stall=%0d ill=%0d required 1 0 0 -1",
               mis_cyc, n_req, n_stall, ill_cyc);
    end
  endtask

  task automatic test_timeout();
    bus_exp_t x;
    bus_q.push_back('{1'b0, 32'h300, 4'b0, 32'h0});
    run_op(1'b1, 1'b0, F3_W, 32'h300, 32'h0,
           32'h11112222, 7, 9);
    checks++;
    if (n_req !== 4 || berr_cyc !== 5 ||
        n_stall !== 5 || lv_cyc !== -1) begin
      errors++;
      $display("FAIL timeout: req=%0d berr=%0d stall=%0d lv=%0d required 4 5 5 -1",
               n_req, berr_cyc, n_stall, lv_cyc);
    end
    checks++;
    if (data_readM !== 32'h00000080) begin
      errors++;
      $display("FAIL timeout_hold: rd=%h required 00000080",
               data_readM);
    end
    x = bus_q.pop_front();
    checks++;
    if (obs_addr !== x.addr || obs_we !== x.we) begin
      errors++;
      $display("FAIL timeout_bus: addr=%h we=%b required %h %b",
               obs_addr, obs_we, x.addr, x.we);
    end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_re = 1'b1;
    funct3M = F3_W; ALUresM = 32'h80;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_re = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy: req=%b stall=%b required 1 1",
               dmem_req, stall_mem);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall_mem, load_valid, bus_err,
         misalign, illegal} !== 6'b0) begin
      errors++;
      $display("FAIL rb_reset: req=%b st=%b lv=%b be=%b mis=%b ill=%b required 0",
               dmem_req, stall_mem, load_valid, bus_err,
               misalign, illegal);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (load_valid !== 1'b0 || dmem_req !== 1'b0 ||
        data_readM !== 32'h0) begin
      errors++;
      $display("FAIL rb_late_ack: lv=%b req=%b rd=%h required 0 0 0",
               load_valid, dmem_req, data_readM);
    end
    load_q.push_back(32'h12345678);
    run_op(1'b1, 1'b0, F3_W, 32'h40, 32'h0,
           32'h12345678, 1, 4);
    checks++;
    if (lv_cyc !== 2 || n_req !== 1 ||
        obs_addr !== 32'h40 ||
        lv_data !== load_q.pop_front()) begin
      errors++;
      $display("FAIL rb_next_lw: lv=%0d req=%0d addr=%h data=%h required 2 1 00000040 12345678",
               lv_cyc, n_req, obs_addr, lv_data);
    end
  endtask

  task automatic test_illegal();
    logic re_t [2];
    logic [2:0] f3_t [2];
    re_t[0] = 1'b0; f3_t[0] = 3'b011;
    re_t[1] = 1'b1; f3_t[1] = F3_W;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, re_t[i], f3_t[i], 32'h20,
             32'h0, 32'h0, 0, 3);
      checks++;
      if (ill_cyc !== 1 || n_stall !== 0 ||
          n_req !== 0 || mis_cyc !== -1) begin
        errors++;
        $display("FAIL illegal[%0d]: ill=%0d stall=%0d req=%0d mis=%0d required 1 0 0 -1",
                 i, ill_cyc, n_stall, n_req, mis_cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_exp_t x;
    logic [31:0] want;
    bus_q.push_back('{1'b1, 32'h4, 4'b1000,
                      32'h5A5A5A5A});
    run_op(1'b0, 1'b1, F3_B, 32'h7, 32'h0000005A,
           32'h0, 1, 3);
    x = bus_q.pop_front();
    checks++;
    if (n_req !== 1 || obs_addr !== x.addr ||
        obs_be !== x.be || obs_wdata !== x.wdata ||
        obs_we !== x.we) begin
      errors++;
      $display("FAIL b2b_sb: %h %b %b %h required %h %b %b %h",
               obs_addr, obs_we, obs_be, obs_wdata,
               x.addr, x.we, x.be, x.wdata);
    end
    load_q.push_back(32'h0000BEEF);
    run_op(1'b1, 1'b0, F3_HU, 32'h6, 32'h0,
           32'hBEEF0000, 1, 3);
    want = load_q.pop_front();
    checks++;
    if (lv_cyc !== 2 || lv_data !== want) begin
      errors++;
      $display("FAIL b2b_lhu: lv=%0d data=%h required 2 %h",
               lv_cyc, lv_data, want);
    end
    load_q.push_back(32'hFFFF8001);
    run_op(1'b1, 1'b0, F3_H, 32'h2, 32'h0,
           32'h80011234, 1, 3);
    want = load_q.pop_front();
    checks++;
    if (lv_cyc !== 2 || lv_data !== want) begin
      errors++;
      $display("FAIL b2b_lh: lv=%0d data=%h required 2 %h",
               lv_cyc, lv_data, want);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_illegal();
    test_back_to_back();
    checks++;
    if (bus_q.size() != 0 || load_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: bus=%0d load=%0d required 0 0",
               bus_q.size(), load_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
